// File: rtl/sound_fx_if.sv
// Event-trigger and audio-status bundle between the game logic and the sound effect player.
interface sound_fx_if;
  logic       sound_en;
  logic       step_trig;
  logic       shot_trig;
  logic       hit_trig;
  logic       audio_out;
  logic       busy;
  logic [1:0] effect_id;
  logic [1:0] note_idx;

  modport master (
    output sound_en, step_trig, shot_trig, hit_trig,
    input  audio_out, busy, effect_id, note_idx
  );

  modport slave (
    input  sound_en, step_trig, shot_trig, hit_trig,
    output audio_out, busy, effect_id, note_idx
  );
endinterface

// File: rtl/sound_fx_player.sv
// Turns one-cycle game event pulses into short fixed note sequences on a 1-bit square wave.
// Higher-priority events preempt lower ones; sound_en low mutes and aborts immediately.
module sound_fx_player #(
  parameter int TICK_CYCLES = 500000,
  parameter int HP_UNIT     = 500
) (
  input  logic        clk,
  input  logic        reset,
  sound_fx_if.slave   bus
);

  localparam int PW = (HP_UNIT > 1)     ? $clog2(HP_UNIT)     : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [1:0] FX_NONE = 2'd0;
  localparam logic [1:0] FX_STEP = 2'd1;
  localparam logic [1:0] FX_SHOT = 2'd2;
  localparam logic [1:0] FX_HIT  = 2'd3;

  typedef enum logic {IDLE, PLAY} state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] code;
    logic [3:0] dur;
  } note_t;

  // Code 0 is a rest; 'last' marks the final note of each effect.
  function automatic note_t note_rom(input logic [1:0] fx, input logic [1:0] idx);
    note_t n;
    n = '{last: 1'b1, code: 8'd0, dur: 4'd0};
    unique case ({fx, idx})
      {FX_STEP, 2'd0}: n = '{last: 1'b1, code: 8'd100, dur: 4'd5};
      {FX_SHOT, 2'd0}: n = '{last: 1'b0, code: 8'd50,  dur: 4'd2};
      {FX_SHOT, 2'd1}: n = '{last: 1'b0, code: 8'd62,  dur: 4'd2};
      {FX_SHOT, 2'd2}: n = '{last: 1'b1, code: 8'd83,  dur: 4'd2};
      {FX_HIT,  2'd0}: n = '{last: 1'b0, code: 8'd125, dur: 4'd3};
      {FX_HIT,  2'd1}: n = '{last: 1'b0, code: 8'd167, dur: 4'd3};
      {FX_HIT,  2'd2}: n = '{last: 1'b0, code: 8'd250, dur: 4'd3};
      {FX_HIT,  2'd3}: n = '{last: 1'b1, code: 8'd0,   dur: 4'd4};
      default:         n = '{last: 1'b1, code: 8'd0,   dur: 4'd0};
    endcase
    return n;
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      eff_q, eff_d;
  logic [1:0]      nidx_q, nidx_d;
  logic            audio_q, audio_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [7:0]      hp_q, hp_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [3:0]      dur_q, dur_d;

  logic [1:0]      trig_id;
  logic            pre_wrap;
  logic            tick_wrap;
  note_t           cur_note;
  note_t           nxt_note;
  note_t           start_note;

  always_comb begin
    if (bus.hit_trig)       trig_id = FX_HIT;
    else if (bus.shot_trig) trig_id = FX_SHOT;
    else if (bus.step_trig) trig_id = FX_STEP;
    else                    trig_id = FX_NONE;
  end

  assign cur_note   = note_rom(eff_q, nidx_q);
  assign nxt_note   = note_rom(eff_q, nidx_q + 2'd1);
  assign start_note = note_rom(trig_id, 2'd0);
  assign pre_wrap   = (pre_q  == PW'(HP_UNIT - 1));
  assign tick_wrap  = (tick_q == TW'(TICK_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    eff_d   = eff_q;
    nidx_d  = nidx_q;
    audio_d = audio_q;
    pre_d   = pre_q;
    hp_d    = hp_q;
    tick_d  = tick_q;
    dur_d   = dur_q;

    if (!bus.sound_en) begin
      state_d = IDLE;
      eff_d   = FX_NONE;
      nidx_d  = 2'd0;
      audio_d = 1'b0;
      pre_d   = '0;
      hp_d    = '0;
      tick_d  = '0;
      dur_d   = '0;
    end else if (trig_id != FX_NONE && (state_q == IDLE || trig_id > eff_q)) begin
      // New effect, or strictly-higher-priority preemption: restart from note 0.
      state_d = PLAY;
      eff_d   = trig_id;
      nidx_d  = 2'd0;
      audio_d = 1'b0;
      pre_d   = '0;
      hp_d    = '0;
      tick_d  = '0;
      dur_d   = start_note.dur;
    end else if (state_q == PLAY) begin
      pre_d = pre_wrap ? '0 : pre_q + PW'(1);
      if (pre_wrap && cur_note.code != 8'd0) begin
        if (hp_q == cur_note.code - 8'd1) begin
          hp_d    = '0;
          audio_d = ~audio_q;
        end else begin
          hp_d = hp_q + 8'd1;
        end
      end

      tick_d = tick_wrap ? '0 : tick_q + TW'(1);
      if (tick_wrap) begin
        if (dur_q == 4'd1) begin
          // Final cycle of this note: next note loads with no gap, or the effect ends.
          audio_d = 1'b0;
          pre_d   = '0;
          hp_d    = '0;
          tick_d  = '0;
          if (cur_note.last) begin
            state_d = IDLE;
            eff_d   = FX_NONE;
            nidx_d  = 2'd0;
            dur_d   = '0;
          end else begin
            nidx_d = nidx_q + 2'd1;
            dur_d  = nxt_note.dur;
          end
        end else begin
          dur_d = dur_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      eff_q   <= FX_NONE;
      nidx_q  <= 2'd0;
      audio_q <= 1'b0;
      pre_q   <= '0;
      hp_q    <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      eff_q   <= eff_d;
      nidx_q  <= nidx_d;
      audio_q <= audio_d;
      pre_q   <= pre_d;
      hp_q    <= hp_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
    end
  end

  assign bus.audio_out = audio_q;
  assign bus.busy      = (state_q == PLAY);
  assign bus.effect_id = eff_q;
  assign bus.note_idx  = nidx_q;

endmodule
